// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types and constants for the MEM->WB elastic stage.
//   DATA_W / RIDX_W   default datapath and register-index widths
//   F3_*              load funct3 encodings used by the load formatter
//   RSRC_*            ResultSrc encodings carried through the stage
//   stage_state_t     occupancy state of the 2-entry stage
//   mem_wb_payload_t  everything that travels with one beat
package mem_wb_pkg;

  localparam int DATA_W = 32;
  localparam int RIDX_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] RSRC_ALU = 2'b00;
  localparam logic [1:0] RSRC_MEM = 2'b01;
  localparam logic [1:0] RSRC_PC4 = 2'b10;
  localparam logic [1:0] RSRC_IMM = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,   // nothing held
    ONE   = 2'd1,   // out_reg valid
    FULL  = 2'd2    // out_reg and skid_reg valid
  } stage_state_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              jump_reg;
    logic [DATA_W-1:0] alu_result;
    logic [RIDX_W-1:0] rd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] read_data;
  } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_elastic_reg_if.sv
// mem_wb_elastic_reg_if: MEM-side and WB-side signals of the elastic stage.
//   master : the environment view (drives M inputs and ReadyW)
//   slave  : the stage view (drives ReadyM and all W outputs)
interface mem_wb_elastic_reg_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              FlushM;
  logic              ValidM;
  logic              ReadyM;
  logic              RegWriteM;
  logic [1:0]        ResultSrcM;
  logic              JumpRegM;
  logic [2:0]        Funct3M;
  logic [WIDTH-1:0]  ALUResultM;
  logic [REG_AW-1:0] RdM;
  logic [WIDTH-1:0]  ImmExtM;
  logic [WIDTH-1:0]  PCPlus4M;
  logic [WIDTH-1:0]  ReadDataM;

  logic              ValidW;
  logic              ReadyW;
  logic              RegWriteW;
  logic [1:0]        ResultSrcW;
  logic              JumpRegW;
  logic [WIDTH-1:0]  ALUResultW;
  logic [REG_AW-1:0] RdW;
  logic [WIDTH-1:0]  ImmExtW;
  logic [WIDTH-1:0]  PCPlus4W;
  logic [WIDTH-1:0]  ReadDataW;

  modport master (
    output FlushM, ValidM, RegWriteM, ResultSrcM, JumpRegM, Funct3M,
           ALUResultM, RdM, ImmExtM, PCPlus4M, ReadDataM, ReadyW,
    input  ReadyM, ValidW, RegWriteW, ResultSrcW, JumpRegW, ALUResultW,
           RdW, ImmExtW, PCPlus4W, ReadDataW
  );

  modport slave (
    input  FlushM, ValidM, RegWriteM, ResultSrcM, JumpRegM, Funct3M,
           ALUResultM, RdM, ImmExtM, PCPlus4M, ReadDataM, ReadyW,
    output ReadyM, ValidW, RegWriteW, ResultSrcW, JumpRegW, ALUResultW,
           RdW, ImmExtW, PCPlus4W, ReadDataW
  );
endinterface

// File: rtl/mem_wb_load_ext.sv
// mem_wb_load_ext: combinational load-data formatter.
//   funct3_i  : load type (LB/LH/LW/LBU/LHU)
//   addr_lo_i : low address bits selecting byte / half
//   rdata_i   : raw memory word
//   rdata_o   : sign/zero-extended result; raw word for LW and unknown types
// WIDTH must be at least 32.
module mem_wb_load_ext
  import mem_wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_LB:   rdata_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_LBU:  rdata_o = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_LHU:  rdata_o = {{(WIDTH-16){1'b0}}, half_sel};
      default: rdata_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/mem_wb_elastic_reg.sv
// mem_wb_elastic_reg: elastic MEM->WB pipeline stage (2-entry skid buffer).
//   CLK, RST : clock, synchronous active-high reset
//   bus      : mem_wb_elastic_reg_if.slave
//              M side: FlushM, ValidM/ReadyM handshake and beat payload
//              W side: ValidW/ReadyW handshake and registered payload
// Optional feature: define MEM_WB_LOAD_EXT_EN to format ReadDataW from
// Funct3M / ALUResultM[1:0] at capture; otherwise the word passes raw.
// The payload struct is sized by the package widths; WIDTH/REG_AW should
// stay equal to mem_wb_pkg::DATA_W / RIDX_W.
module mem_wb_elastic_reg
  import mem_wb_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int REG_AW = RIDX_W
) (
  input  logic CLK,
  input  logic RST,
  mem_wb_elastic_reg_if.slave bus
);
  stage_state_t    state_q, state_d;
  mem_wb_payload_t out_q, out_d;
  mem_wb_payload_t skid_q, skid_d;
  mem_wb_payload_t in_beat;

  logic [WIDTH-1:0]  rdata_fmt;
  logic [REG_AW-1:0] rd_in;
  logic              accept, drain, out_vld, ready;

`ifdef MEM_WB_LOAD_EXT_EN
  mem_wb_load_ext #(.WIDTH(WIDTH)) u_load_ext (
    .funct3_i  (bus.Funct3M),
    .addr_lo_i (bus.ALUResultM[1:0]),
    .rdata_i   (bus.ReadDataM),
    .rdata_o   (rdata_fmt)
  );
`else
  assign rdata_fmt = bus.ReadDataM;
`endif

  assign rd_in = bus.RdM;

  always_comb begin
    in_beat            = '0;
    in_beat.reg_write  = bus.RegWriteM;
    in_beat.result_src = bus.ResultSrcM;
    in_beat.jump_reg   = bus.JumpRegM;
    in_beat.alu_result = bus.ALUResultM;
    in_beat.rd         = rd_in;
    in_beat.imm_ext    = bus.ImmExtM;
    in_beat.pc_plus4   = bus.PCPlus4M;
    in_beat.read_data  = rdata_fmt;
  end

  // Ready depends only on registered state: no ReadyW -> ReadyM path.
  assign ready   = (state_q != FULL);
  assign out_vld = (state_q != EMPTY);
  assign accept  = bus.ValidM & ready;
  assign drain   = out_vld & bus.ReadyW;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (bus.FlushM) begin
      // Input beat is dropped; stale payload may remain except reg_write.
      state_d         = EMPTY;
      out_d.reg_write = 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          out_d   = in_beat;
        end
        ONE: begin
          if (accept && drain) begin
            out_d = in_beat;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_beat;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: if (drain) begin
          state_d = ONE;
          out_d   = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.ReadyM     = ready;
  assign bus.ValidW     = out_vld;
  // A bubble must never write the register file.
  assign bus.RegWriteW  = out_q.reg_write & out_vld;
  assign bus.ResultSrcW = out_q.result_src;
  assign bus.JumpRegW   = out_q.jump_reg;
  assign bus.ALUResultW = out_q.alu_result;
  assign bus.RdW        = out_q.rd;
  assign bus.ImmExtW    = out_q.imm_ext;
  assign bus.PCPlus4W   = out_q.pc_plus4;
  assign bus.ReadDataW  = out_q.read_data;
endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
module tb_mem_wb_elastic_reg;
  logic CLK, RST;
  int total = 0;
  int bad   = 0;

  mem_wb_elastic_reg_if #(.WIDTH(32), .REG_AW(5)) bus ();

  mem_wb_elastic_reg #(.WIDTH(32), .REG_AW(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw_en;
    logic [1:0]  rsrc;
    logic        jr;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [31:0] rdata;
  } beat_t;

  typedef struct {
    logic       rst, flush, vm, rw;
    logic [4:0] rd;
    logic       evw, erm;
    logic [4:0] erd;
    logic       chk_rd, zero;
  } vec_t;

  vec_t  tbl[$];
  beat_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add_v(input logic rst, flush, vm, rw, input logic [4:0] rd,
                       input logic evw, erm, input logic [4:0] erd, input logic chk_rd, zero);
    vec_t v;
    v.rst = rst; v.flush = flush; v.vm = vm; v.rw = rw; v.rd = rd;
    v.evw = evw; v.erm = erm; v.erd = erd; v.chk_rd = chk_rd; v.zero = zero;
    tbl.push_back(v);
  endtask

  task automatic drive_beat(input beat_t b, input logic [2:0] f3);
    bus.RegWriteM  = b.rw_en;
    bus.ResultSrcM = b.rsrc;
    bus.JumpRegM   = b.jr;
    bus.ALUResultM = b.alu;
    bus.RdM        = b.rd;
    bus.ImmExtM    = b.imm;
    bus.PCPlus4M   = b.pc4;
    bus.ReadDataM  = b.rdata;
    bus.Funct3M    = f3;
  endtask

  function automatic beat_t beat_of_rd(input logic [4:0] rd);
    beat_t b;
    b.rw_en = 1'b1; b.rsrc = rd[1:0]; b.jr = rd[0];
    b.alu = 32'h1000_0000 | 32'(rd); b.rd = rd;
    b.imm = 32'(rd) * 3; b.pc4 = 32'(rd) * 4 + 4;
    b.rdata = 32'hA500_0000 | 32'(rd);
    return b;
  endfunction

  // Load formatting from the load-type rules, via shifts on the word.
  function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
`ifdef MEM_WB_LOAD_EXT_EN
    logic [31:0] b, h;
    b = w >> (8 * int'(a));
    h = w >> (16 * int'(a[1]));
    case (f3)
      3'b000:  return 32'($signed(b[7:0]));
      3'b001:  return 32'($signed(h[15:0]));
      3'b100:  return 32'(b[7:0]);
      3'b101:  return 32'(h[15:0]);
      default: return w;
    endcase
`else
    if (f3 == 3'b111 && a == 2'b11) return w;
    return w;
`endif
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_zero_ctl"}, {26'd0, bus.RegWriteW, bus.ResultSrcW, bus.JumpRegW, 2'b00}, 32'd0);
    check({tag, "_zero_rd"},  32'(bus.RdW), 32'd0);
    check({tag, "_zero_alu"}, bus.ALUResultW, 32'd0);
    check({tag, "_zero_imm"}, bus.ImmExtW, 32'd0);
    check({tag, "_zero_pc4"}, bus.PCPlus4W, 32'd0);
    check({tag, "_zero_rdat"}, bus.ReadDataW, 32'd0);
  endtask

  logic [2:0]  lx_f3[4];
  logic [1:0]  lx_a[4];
  logic [31:0] lx_exp[4];

  initial begin
    beat_t b;
    RST = 1'b1;
    bus.FlushM = 1'b0; bus.ValidM = 1'b0; bus.ReadyW = 1'b1;
    drive_beat(beat_of_rd(5'd0), 3'b010);

    // rst flush vm rw rd | vw rm rdw chk zero
    add_v(1,0,0,1,0, 0,1,0, 0,1);
    add_v(1,0,0,1,0, 0,1,0, 0,1);
    for (int i = 1; i <= 8; i++) add_v(0,0,1,1,5'(i), 1,1,5'(i), 1,0);
    add_v(0,0,0,1,0, 0,1,0, 0,0);
    // backpressure
    add_v(0,0,1,0,3, 1,1,3, 1,0);
    add_v(0,0,1,0,4, 1,0,3, 1,0);
    add_v(0,0,0,0,0, 1,0,3, 1,0);
    add_v(0,0,0,1,0, 1,1,4, 1,0);
    add_v(0,0,0,1,0, 0,1,0, 0,0);
    // flush while FULL with a live input beat
    add_v(0,0,1,0,5, 1,1,5, 1,0);
    add_v(0,0,1,0,6, 1,0,5, 1,0);
    add_v(0,1,1,0,7, 0,1,0, 0,0);
    add_v(0,0,0,1,0, 0,1,0, 0,0);
    add_v(0,0,0,1,0, 0,1,0, 0,0);
    // reset while FULL
    add_v(0,0,1,0,9,  1,1,9, 1,0);
    add_v(0,0,1,0,10, 1,0,9, 1,0);
    add_v(1,0,1,0,11, 0,1,0, 0,1);
    add_v(0,0,0,1,0,  0,1,0, 0,1);

    foreach (tbl[i]) begin
      RST = tbl[i].rst; bus.FlushM = tbl[i].flush;
      bus.ValidM = tbl[i].vm; bus.ReadyW = tbl[i].rw;
      drive_beat(beat_of_rd(tbl[i].rd), 3'b010);
      step();
      check($sformatf("tbl%0d_validw", i), 32'(bus.ValidW), 32'(tbl[i].evw));
      check($sformatf("tbl%0d_readym", i), 32'(bus.ReadyM), 32'(tbl[i].erm));
      check($sformatf("tbl%0d_regwr", i), 32'(bus.RegWriteW), 32'(tbl[i].evw));
      if (tbl[i].chk_rd) begin
        b = beat_of_rd(tbl[i].erd);
        check($sformatf("tbl%0d_rdw", i), 32'(bus.RdW), 32'(tbl[i].erd));
        check($sformatf("tbl%0d_alu", i), bus.ALUResultW, b.alu);
        check($sformatf("tbl%0d_rdata", i), bus.ReadDataW, b.rdata);
      end
      if (tbl[i].zero) check_zero($sformatf("tbl%0d", i));
    end

    // load formatting
    lx_f3[0] = 3'b000; lx_a[0] = 2'd0;
    lx_f3[1] = 3'b100; lx_a[1] = 2'd1;
    lx_f3[2] = 3'b001; lx_a[2] = 2'd2;
    lx_f3[3] = 3'b010; lx_a[3] = 2'd0;
`ifdef MEM_WB_LOAD_EXT_EN
    lx_exp[0] = 32'hFFFF_FF81; lx_exp[1] = 32'h0000_007F;
    lx_exp[2] = 32'hFFFF_80F0; lx_exp[3] = 32'h80F0_7F81;
`else
    for (int i = 0; i < 4; i++) lx_exp[i] = 32'h80F0_7F81;
`endif
    RST = 1'b0; bus.FlushM = 1'b0; bus.ReadyW = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = beat_of_rd(5'(i + 1));
      b.alu = 32'h0000_1000 | 32'(lx_a[i]);
      b.rdata = 32'h80F0_7F81;
      drive_beat(b, lx_f3[i]);
      bus.ValidM = 1'b1;
      step();
      check($sformatf("ldx%0d_validw", i), 32'(bus.ValidW), 32'd1);
      check($sformatf("ldx%0d_rdata", i), bus.ReadDataW, lx_exp[i]);
    end
    bus.ValidM = 1'b0;
    step();

    // randomized traffic against a queue model
    RST = 1'b1; step(); RST = 1'b0;
    q.delete();
    for (int n = 0; n < 600; n++) begin
      logic r_rst, r_fl, r_vm, r_rw, acc, drn;
      logic [2:0] f3;
      r_rst = ($urandom_range(0, 59) == 0);
      r_fl  = ($urandom_range(0, 15) == 0);
      r_vm  = 1'($urandom);
      r_rw  = ($urandom_range(0, 3) != 0);
      f3    = 3'($urandom);
      b.rw_en = 1'($urandom); b.rsrc = 2'($urandom); b.jr = 1'($urandom);
      b.alu = $urandom; b.rd = 5'($urandom); b.imm = $urandom;
      b.pc4 = $urandom; b.rdata = $urandom;
      RST = r_rst; bus.FlushM = r_fl; bus.ValidM = r_vm; bus.ReadyW = r_rw;
      drive_beat(b, f3);
      acc = r_vm && (q.size() < 2);
      drn = (q.size() > 0) && r_rw;
      b.rdata = ref_fmt(f3, b.alu[1:0], b.rdata);
      step();
      if (r_rst || r_fl) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
      check("rnd_validw", 32'(bus.ValidW), 32'(q.size() > 0));
      check("rnd_readym", 32'(bus.ReadyM), 32'(q.size() < 2));
      if (r_rst) check_zero("rnd_rst");
      if (q.size() > 0) begin
        check("rnd_ctl", {23'd0, bus.RegWriteW, bus.ResultSrcW, bus.JumpRegW, bus.RdW},
              {23'd0, q[0].rw_en, q[0].rsrc, q[0].jr, q[0].rd});
        check("rnd_alu", bus.ALUResultW, q[0].alu);
        check("rnd_imm", bus.ImmExtW, q[0].imm);
        check("rnd_pc4", bus.PCPlus4W, q[0].pc4);
        check("rnd_rdata", bus.ReadDataW, q[0].rdata);
      end else begin
        check("rnd_bubble_regwr", 32'(bus.RegWriteW), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
